class_arbiter: RTL and testbench
================================

Name: class_arbiter

Overview:
- Downstream neighbour of the class splitter.
- Drains the two per-class FIFOs (class 0, class 1) that the splitter fills, and merges them onto one output stream toward the next switch stage.
- Uses weighted round-robin: class 1 is favoured but class 0 cannot starve. Honors downstream almost-full backpressure.
- Keeps per-class forwarded-word counters for debug.

Parameters:
- DATA_SIZE, 10, word width; bit DATA_SIZE-1 is the class bit, passed through unchanged.
- WEIGHT, 4, max consecutive class-1 grants while class 0 is pending (legal range 1..15).
- CNT_SIZE, 8, width of the per-class forwarded counters.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- fifo0_data  input  DATA_SIZE  class-0 FIFO read data; valid the cycle after pop0.
- fifo0_empty  input  1  class-0 FIFO empty flag.
- fifo1_data  input  DATA_SIZE  class-1 FIFO read data; valid the cycle after pop1.
- fifo1_empty  input  1  class-1 FIFO empty flag.
- af_down  input  1  downstream almost-full; while high, no new pops.
- pop0  output  1  class-0 FIFO read strobe (combinational from state/flags).
- pop1  output  1  class-1 FIFO read strobe (combinational from state/flags).
- data_out  output  DATA_SIZE  registered merged word.
- valid_out  output  1  data_out qualifier.
- sent0_cnt  output  CNT_SIZE  class-0 words forwarded.
- sent1_cnt  output  CNT_SIZE  class-1 words forwarded.

Behaviour:
- Reset low:
  - state=SERVE1, burst=0, pend_sel=0, pend_vld=0.
  - data_out=0, valid_out=0, sent0_cnt=0, sent1_cnt=0.
  - pop0=pop1=0 immediately, asynchronously.
  - Words in flight at reset assertion are discarded.
- Pop rule: at most one pop per cycle; pop0 and pop1 are never high together. No pop while af_down=1 or reset low.
- Latency: pop in cycle N; FIFO data in N+1, captured with pend_sel; data_out/valid_out visible in N+2. Throughput is one word per cycle.
- valid_out=1 exactly one cycle per popped word. When not valid, data_out holds its last value.
- The sent counter for the selected class increments in the cycle valid_out rises for that word. Counters wrap modulo 2^CNT_SIZE.
- State SERVE1, with af_down=0:
  - fifo1 non-empty and (burst<WEIGHT or fifo0 empty): pop1, burst=min(burst+1, WEIGHT). Saturates while fifo0 is empty.
  - fifo1 non-empty, burst==WEIGHT, fifo0 non-empty: pop0, burst=0, stay in SERVE1. This is the fairness slot.
  - fifo1 empty, fifo0 non-empty: pop0, burst=0 (work-conserving).
  - Both empty: idle, burst held.
- SERVE0 state:
  - Entered only when the fairness slot is taken while af_down rises in the same decision cycle, i.e. the grant is owed but blocked.
  - In SERVE0 with af_down=0: pop0 if fifo0 non-empty, then go to SERVE1 with burst=0.
  - If fifo0 is empty, go to SERVE1 and apply the SERVE1 rules in the same cycle.
- af_down high: state and burst frozen; already-issued pops still complete to data_out (at most 1 word after af_down rises).
- Empty flag rising in the same cycle as a decision: the flag is sampled that cycle; no pop to an empty FIFO.
- Class bit is not inspected; data is forwarded bit-exact.

Decomposition:
- Shared package/header class_pkg: DATA_SIZE default, CLASS_BIT index, state encodings SERVE1=1'b0, SERVE0=1'b1.
- One natural sub-module: wrr_sel (state, burst counter, pop decision). class_arbiter holds the output pipeline register and counters.

Test Plan:
- Reset released, both FIFOs empty, af_down=0 -> pop0=pop1=0, valid_out=0, counters 0 for 20 cycles.
- fifo1 holds 6 words (10'h201..206), fifo0 empty -> pop1 six consecutive cycles; data_out 201..206 in cycles N+2..N+7; sent1_cnt=6.
- Both FIFOs hold 10 words, WEIGHT=4 -> output class order 1,1,1,1,0,1,1,1,1,0; sent1=8, sent0=2 after 10 valid words.
- af_down raised mid-burst after 2 class-1 pops -> no further pops; at most one more valid_out; on release, class-1 pops resume until the burst of 4 completes, then one class-0 word.
- reset asserted one cycle after a pop -> pop/valid_out drop immediately, popped word never appears, counters 0; normal order resumes after release.
- Class-1 traffic of 300 words with fifo0 empty -> sent1_cnt wraps 255->0 at word 256, ending at 44.

Source files
------------

// File: rtl/class_pkg.sv
// Shared definitions for the class arbiter: default word width, class bit position,
// arbiter state encoding and the saturating burst helper.
package class_pkg;

  localparam int unsigned DATA_SIZE_DEF = 10;
  localparam int unsigned CLASS_BIT     = DATA_SIZE_DEF - 1;
  localparam int unsigned BURST_W       = 4;

  typedef enum logic {
    Serve1 = 1'b0,
    Serve0 = 1'b1
  } state_e;

  function automatic logic [BURST_W-1:0] burst_inc(input logic [BURST_W-1:0] burst,
                                                   input logic [BURST_W-1:0] weight);
    return (burst < weight) ? burst + 4'd1 : burst;
  endfunction

endpackage

// File: rtl/class_arbiter_if.sv
// FIFO-side, downstream and debug-counter signals of the class arbiter.
interface class_arbiter_if #(
  parameter int unsigned DATA_SIZE = 10,
  parameter int unsigned CNT_SIZE  = 8
);
  logic [DATA_SIZE-1:0] fifo0_data;
  logic                 fifo0_empty;
  logic [DATA_SIZE-1:0] fifo1_data;
  logic                 fifo1_empty;
  logic                 af_down;
  logic                 pop0;
  logic                 pop1;
  logic [DATA_SIZE-1:0] data_out;
  logic                 valid_out;
  logic [CNT_SIZE-1:0]  sent0_cnt;
  logic [CNT_SIZE-1:0]  sent1_cnt;

  modport master (
    output fifo0_data, fifo0_empty, fifo1_data, fifo1_empty, af_down,
    input  pop0, pop1, data_out, valid_out, sent0_cnt, sent1_cnt
  );

  modport slave (
    input  fifo0_data, fifo0_empty, fifo1_data, fifo1_empty, af_down,
    output pop0, pop1, data_out, valid_out, sent0_cnt, sent1_cnt
  );
endinterface

// File: rtl/class_arbiter_wrr_sel.sv
// Weighted round-robin pop decision: favours class 1 for up to WEIGHT consecutive
// grants while class 0 waits, then gives class 0 one slot.
module class_arbiter_wrr_sel
  import class_pkg::*;
#(
  parameter int unsigned WEIGHT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic fifo0_empty_i,
  input  logic fifo1_empty_i,
  input  logic af_down_i,
  output logic pop0_o,
  output logic pop1_o
);

  localparam logic [BURST_W-1:0] WeightL = BURST_W'(WEIGHT);

  state_e               state_q, state_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic                 pop0, pop1;

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    pop0    = 1'b0;
    pop1    = 1'b0;
    if (!af_down_i) begin
      if (state_q == Serve0 && !fifo0_empty_i) begin
        pop0    = 1'b1;
        state_d = Serve1;
        burst_d = '0;
      end else begin
        state_d = Serve1;
        if (!fifo1_empty_i && (burst_q < WeightL || fifo0_empty_i)) begin
          pop1    = 1'b1;
          burst_d = burst_inc(burst_q, WeightL);
        end else if (!fifo0_empty_i) begin
          // Fairness slot or work-conserving class-0 grant.
          pop0    = 1'b1;
          burst_d = '0;
        end
      end
    end else if (state_q == Serve1 && !fifo1_empty_i && !fifo0_empty_i &&
                 burst_q == WeightL) begin
      // Fairness grant owed but blocked by backpressure; remember it.
      state_d = Serve0;
      burst_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Serve1;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  // Gate with reset so strobes drop asynchronously.
  assign pop0_o = pop0 & rst_ni;
  assign pop1_o = pop1 & rst_ni;

endmodule

// File: rtl/class_arbiter.sv
// Merges the class-0 and class-1 FIFOs onto one registered output stream and
// keeps per-class forwarded-word counters.
module class_arbiter
  import class_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
  parameter int unsigned WEIGHT    = 4,
  parameter int unsigned CNT_SIZE  = 8
) (
  input  logic           clk,
  input  logic           reset,
  class_arbiter_if.slave bus
);

  logic                 pop0, pop1;
  logic                 pend_vld_q, pend_sel_q;
  logic [DATA_SIZE-1:0] data_q;
  logic                 valid_q;
  logic [CNT_SIZE-1:0]  cnt0_q, cnt1_q;

  class_arbiter_wrr_sel #(
    .WEIGHT (WEIGHT)
  ) u_wrr_sel (
    .clk_i         (clk),
    .rst_ni        (reset),
    .fifo0_empty_i (bus.fifo0_empty),
    .fifo1_empty_i (bus.fifo1_empty),
    .af_down_i     (bus.af_down),
    .pop0_o        (pop0),
    .pop1_o        (pop1)
  );

  // FIFO data arrives the cycle after the pop; pend_* tags that cycle's word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_vld_q <= 1'b0;
      pend_sel_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      pend_vld_q <= pop0 | pop1;
      pend_sel_q <= pop1;
      valid_q    <= pend_vld_q;
      if (pend_vld_q) begin
        data_q <= pend_sel_q ? bus.fifo1_data : bus.fifo0_data;
        if (pend_sel_q) cnt1_q <= cnt1_q + 1'b1;
        else            cnt0_q <= cnt0_q + 1'b1;
      end
    end
  end

  assign bus.pop0      = pop0;
  assign bus.pop1      = pop1;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.sent0_cnt = cnt0_q;
  assign bus.sent1_cnt = cnt1_q;

endmodule

// File: tb/tb_class_arbiter.sv
// Directed bench for class_arbiter: behavioural FIFOs, output log, hand-computed orders.
module tb_class_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  class_arbiter_if #(.DATA_SIZE(10), .CNT_SIZE(8)) bus ();

  class_arbiter #(
    .DATA_SIZE (10),
    .WEIGHT    (4),
    .CNT_SIZE  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural FIFOs: read data appears the cycle after a pop.
  logic [9:0] m0 [0:1023];
  logic [9:0] m1 [0:1023];
  int w0 = 0, w1 = 0, r0 = 0, r1 = 0;
  assign bus.fifo0_empty = (r0 == w0);
  assign bus.fifo1_empty = (r1 == w1);

  always @(posedge clk) begin
    if (bus.pop0) begin
      bus.fifo0_data <= m0[r0];
      r0 <= r0 + 1;
    end
    if (bus.pop1) begin
      bus.fifo1_data <= m1[r1];
      r1 <= r1 + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0] log_d  [0:1023];
  int         log_c  [0:1023];
  logic [7:0] log_s0 [0:1023];
  logic [7:0] log_s1 [0:1023];
  int         logn = 0;
  logic       both_pop = 1'b0;

  always @(posedge clk) begin
    #1;
    if (bus.valid_out && logn < 1024) begin
      log_d[logn]  = bus.data_out;
      log_c[logn]  = cyc;
      log_s0[logn] = bus.sent0_cnt;
      log_s1[logn] = bus.sent1_cnt;
      logn++;
    end
    if (bus.pop0 && bus.pop1) both_pop = 1'b1;
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Compare a logged segment against a class pattern; class-k words are sequential from start_k.
  task automatic check_order(input string tag, input int base, input string pat,
                             input logic [9:0] start0, input logic [9:0] start1);
    logic [9:0] n0, n1, exp;
    n0 = start0;
    n1 = start1;
    for (int k = 0; k < pat.len(); k++) begin
      if (pat[k] == "1") begin exp = n1; n1 = n1 + 10'd1; end
      else               begin exp = n0; n0 = n0 + 10'd1; end
      check($sformatf("%s[%0d]", tag, k), 32'(log_d[base+k]), 32'(exp));
    end
  endtask

  int base, c0;

  initial begin
    bus.af_down = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    check("rst_outputs", {28'd0, bus.pop0, bus.pop1, bus.valid_out, |bus.data_out}, 32'd0);
    check("rst_cnts", {16'd0, bus.sent0_cnt, bus.sent1_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Idle with both FIFOs empty
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle", {28'd0, bus.pop0, bus.pop1, bus.valid_out,
                     |(bus.sent0_cnt | bus.sent1_cnt)}, 32'd0);
    end

    // Six class-1 words, fifo0 empty
    base = logn;
    @(negedge clk);
    for (int i = 0; i < 6; i++) m1[w1+i] = 10'h201 + 10'(i);
    w1 += 6;
    #1;
    check("c1_first_pop", {30'd0, bus.pop0, bus.pop1}, 32'd1);
    c0 = cyc;
    repeat (12) @(negedge clk);
    check("c1_count", 32'(logn - base), 32'd6);
    check_order("c1_data", base, "111111", 10'h000, 10'h201);
    check("c1_first_lat", 32'(log_c[base]), 32'(c0 + 2));
    check("c1_last_lat", 32'(log_c[base+5]), 32'(c0 + 7));
    check("c1_sent1", 32'(bus.sent1_cnt), 32'd6);
    check("c1_sent0", 32'(bus.sent0_cnt), 32'd0);

    // Both FIFOs with ten words each
    do_reset();
    base = logn;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      m0[w0+i] = 10'h0A0 + 10'(i);
      m1[w1+i] = 10'h2B0 + 10'(i);
    end
    w0 += 10;
    w1 += 10;
    repeat (30) @(negedge clk);
    check("wrr_count", 32'(logn - base), 32'd20);
    check_order("wrr_data", base, "11110111101100000000", 10'h0A0, 10'h2B0);
    check("wrr_sent1_at10", 32'(log_s1[base+9]), 32'd8);
    check("wrr_sent0_at10", 32'(log_s0[base+9]), 32'd2);
    check("wrr_back2back", 32'(log_c[base+19] - log_c[base]), 32'd19);

    // Backpressure after two class-1 pops
    do_reset();
    base = logn;
    @(negedge clk);
    for (int i = 0; i < 8; i++) m1[w1+i] = 10'h2C0 + 10'(i);
    for (int i = 0; i < 3; i++) m0[w0+i] = 10'h0C0 + 10'(i);
    w1 += 8;
    w0 += 3;
    #1;
    check("af_pop_a", {30'd0, bus.pop0, bus.pop1}, 32'd1);
    @(negedge clk);
    #1;
    check("af_pop_b", {30'd0, bus.pop0, bus.pop1}, 32'd1);
    @(negedge clk);
    bus.af_down = 1'b1;
    #1;
    check("af_nopop_0", {30'd0, bus.pop0, bus.pop1}, 32'd0);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("af_nopop_%0d", i), {30'd0, bus.pop0, bus.pop1}, 32'd0);
    end
    check("af_inflight", 32'(logn - base), 32'd2);
    bus.af_down = 1'b0;
    repeat (20) @(negedge clk);
    check("af_count", 32'(logn - base), 32'd11);
    check_order("af_data", base, "11110111100", 10'h0C0, 10'h2C0);

    // Reset one cycle after a pop
    do_reset();
    base = logn;
    @(negedge clk);
    for (int i = 0; i < 3; i++) m1[w1+i] = 10'h2D0 + 10'(i);
    w1 += 3;
    #1;
    check("rp_pop", {30'd0, bus.pop0, bus.pop1}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rp_async", {28'd0, bus.pop0, bus.pop1, bus.valid_out, |bus.data_out}, 32'd0);
    check("rp_cnts", {16'd0, bus.sent0_cnt, bus.sent1_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("rp_count", 32'(logn - base), 32'd2);
    check_order("rp_data", base, "11", 10'h000, 10'h2D1);
    check("rp_sent1", 32'(bus.sent1_cnt), 32'd2);

    // Counter wrap with 300 class-1 words
    do_reset();
    base = logn;
    @(negedge clk);
    for (int i = 0; i < 300; i++) m1[w1+i] = 10'h200 | 10'(i % 512);
    w1 += 300;
    repeat (310) @(negedge clk);
    check("wrap_count", 32'(logn - base), 32'd300);
    check("wrap_pre", 32'(log_s1[base+254]), 32'd255);
    check("wrap_zero", 32'(log_s1[base+255]), 32'd0);
    check("wrap_sent1", 32'(bus.sent1_cnt), 32'd44);
    check("wrap_sent0", 32'(bus.sent0_cnt), 32'd0);
    check("wrap_last", 32'(log_d[base+299]), 32'h32B);

    check("never_both_pop", 32'(both_pop), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
